// File: rtl/counter_74163_pkg.sv
// Shared types and constants for the 74163-based interval timer:
// state encoding, nibble/count widths and the 8-bit terminal value.
package counter_74163_pkg;

  localparam int NIBBLE_W = 4;
  localparam int COUNT_W  = 8;
  localparam logic [COUNT_W-1:0] TERMINAL = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/counter_74163.sv
// One 4-bit synchronous counter slice (74163 behaviour): sync clear over
// sync load over count; RCO = T and Q at all-ones.
module counter_74163
  import counter_74163_pkg::*;
(
  input  logic                clk,
  input  logic                Clear_N,
  input  logic                Load_N,
  input  logic                P,
  input  logic                T,
  input  logic [NIBBLE_W-1:0] D,
  output logic [NIBBLE_W-1:0] Q,
  output logic                RCO
);

  logic [NIBBLE_W-1:0] q_q;
  logic [NIBBLE_W-1:0] q_d;
  logic [NIBBLE_W-1:0] nib_full_s;

  always_comb begin
    nib_full_s = TERMINAL[NIBBLE_W-1:0];
    q_d        = q_q;
    if (!Clear_N) begin
      q_d = '0;
    end else if (!Load_N) begin
      q_d = D;
    end else if (P && T) begin
      q_d = q_q + 4'd1;
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign Q   = q_q;
  assign RCO = T & (q_q == nib_full_s);

endmodule

// File: rtl/counter_74163_timer_ctrl.sv
// Interval-timer controller driving two cascaded 74163 nibble counters.
// Define COUNTER_74163_AUTORELOAD_EN for periodic mode; default is one-shot.
module counter_74163_timer_ctrl
  import counter_74163_pkg::*;
#(
  parameter int PRESET_W = COUNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [PRESET_W-1:0] preset,
  input  logic                pause,
  input  logic                abort,
  input  logic                carry_lo,
  input  logic                carry_hi,
  output logic                Load_N,
  output logic                Clear_N,
  output logic                P,
  output logic                T_lo,
  output logic                T_hi,
  output logic [NIBBLE_W-1:0] Din1,
  output logic [NIBBLE_W-1:0] Din2,
  output logic                busy,
  output logic                done
);

  if (PRESET_W != COUNT_W) begin : g_bad_width
    $error("counter_74163_timer_ctrl: PRESET_W must be 8");
  end

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] preset_q, preset_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               run_s, abort_s, term_s, load_s;

  always_comb begin
    run_s    = (state_q == ST_RUN);
    abort_s  = abort && (state_q != ST_IDLE);
    // carry_hi can only be high with T_lo=1, so it already implies "unpaused at FF"
    term_s   = run_s && carry_hi && !abort && !reset;
    load_s   = ((state_q == ST_LOAD) || term_s) && !abort_s && !reset;
    state_d  = state_q;
    preset_d = preset_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          preset_d = preset;
          state_d  = ST_LOAD;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (term_s) begin
`ifdef COUNTER_74163_AUTORELOAD_EN
          state_d = ST_RUN;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (reset) begin
      state_d  = ST_IDLE;
      preset_d = '0;
    end else begin
      preset_d = preset_d;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = term_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      preset_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Load_N  = ~load_s;
  assign Clear_N = ~(reset | abort_s);
  assign P       = run_s & ~pause & ~reset;
  assign T_lo    = run_s & ~pause & ~reset;
  assign T_hi    = T_lo & carry_lo;
  assign Din1    = preset_q[NIBBLE_W-1:0];
  assign Din2    = preset_q[COUNT_W-1:NIBBLE_W];
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_counter_74163_timer_ctrl.sv
// Scoreboard bench: controller plus two counter_74163 slices; expected
// results are queued when an operation is launched and popped once measured.
module tb_counter_74163_timer_ctrl;

`ifdef COUNTER_74163_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1, start = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [7:0] preset = 8'h00;
  logic       carry_lo, carry_hi, Load_N, Clear_N, P, T_lo, T_hi, busy, done;
  logic [3:0] Din1, Din2, q_lo, q_hi;
  logic [7:0] q;

  assign q = {q_hi, q_lo};

  always #5 clk = ~clk;

  counter_74163_timer_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .preset(preset), .pause(pause),
    .abort(abort), .carry_lo(carry_lo), .carry_hi(carry_hi), .Load_N(Load_N),
    .Clear_N(Clear_N), .P(P), .T_lo(T_lo), .T_hi(T_hi), .Din1(Din1),
    .Din2(Din2), .busy(busy), .done(done)
  );

  counter_74163 u_lo (
    .clk(clk), .Clear_N(Clear_N), .Load_N(Load_N), .P(P), .T(T_lo),
    .D(Din1), .Q(q_lo), .RCO(carry_lo)
  );

  counter_74163 u_hi (
    .clk(clk), .Clear_N(Clear_N), .Load_N(Load_N), .P(P), .T(T_hi),
    .D(Din2), .Q(q_hi), .RCO(carry_hi)
  );

  int    checks = 0;
  int    errors = 0;
  string tag_q[$];
  int    val_q[$];

  typedef struct {
    int lat; int q_end; int din_end; int busy_end; int done_cnt; int done_next;
    int run_cyc; int load_lows; int clr_lows; int seq_err; int thi_err; int rst_bad;
  } res_t;

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic pop_check(input int act);
    if (val_q.size() == 0) check_eq("sb_underflow", 1, 0);
    else check_eq(tag_q.pop_front(), act, val_q.pop_front());
  endtask

  task automatic expect_res(input string n, input int lat, input int qe, input int din,
                            input int bsy, input int dc, input int dn, input int rc,
                            input int ld, input int cl);
    push_exp({n, ".lat"}, lat);        push_exp({n, ".q_end"}, qe);
    push_exp({n, ".din"}, din);        push_exp({n, ".busy"}, bsy);
    push_exp({n, ".done_cnt"}, dc);    push_exp({n, ".done_next"}, dn);
    push_exp({n, ".run_cyc"}, rc);     push_exp({n, ".load_lows"}, ld);
    push_exp({n, ".clr_lows"}, cl);    push_exp({n, ".seq_err"}, 0);
    push_exp({n, ".thi_err"}, 0);      push_exp({n, ".rst_bad"}, 0);
  endtask

  // Plain completed operation: LOAD + terminal give two Load_N lows.
  task automatic expect_normal(input string n, input logic [7:0] p, input int extra);
    int period;
    period = 256 - int'(p);
    expect_res(n, period + 2 + extra, int'(p), int'(p), int'(AUTO), 1,
               int'(AUTO && period == 1), period, 2, 0);
  endtask

  task automatic score_res(input res_t r);
    pop_check(r.lat);      pop_check(r.q_end);     pop_check(r.din_end);
    pop_check(r.busy_end); pop_check(r.done_cnt);  pop_check(r.done_next);
    pop_check(r.run_cyc);  pop_check(r.load_lows); pop_check(r.clr_lows);
    pop_check(r.seq_err);  pop_check(r.thi_err);   pop_check(r.rst_bad);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Launch at edge 0 and measure until one cycle past done, or a few cycles past abort/reset.
  task automatic run_op(input logic [7:0] p, input logic [7:0] p2, input int pause_q,
                        input int pause_len, input int abort_q, input int start2_at,
                        input int reset_at, output res_t r);
    int         stop_at, pause_left;
    bit         paused_once, aborted, inc_prev, hold_prev;
    logic [7:0] q_prev;
    r = '{default: 0};
    r.lat = -1; stop_at = 700; pause_left = 0; paused_once = 0; aborted = 0;
    inc_prev = 0; hold_prev = 0; q_prev = 8'h00;
    start = 1'b1; preset = p;
    @(posedge clk); #1;
    start = 1'b0; preset = 8'h5A;
    for (int cyc = 1; cyc < 700; cyc++) begin
      if (inc_prev && q != q_prev + 8'd1) r.seq_err++;
      if (hold_prev && q != q_prev) r.seq_err++;
      start = (cyc == start2_at);
      if (start) preset = p2;
      reset = (cyc == reset_at);
      if (cyc >= 2 && !paused_once && pause_q >= 0 && q == pause_q[7:0]) begin
        paused_once = 1; pause_left = pause_len;
      end
      pause = (pause_left > 0);
      if (pause_left > 0) pause_left--;
      abort = (cyc >= 2 && !aborted && abort_q >= 0 && q == abort_q[7:0]);
      if (abort || reset) begin aborted = 1; stop_at = cyc + 4; end
      @(negedge clk);
      if (r.lat > 0 && cyc == r.lat + 1) begin
        r.done_next = int'(done);
        break;
      end
      if (done && r.lat < 0) begin
        r.lat = cyc; r.q_end = int'(q); r.busy_end = int'(busy); r.din_end = int'({Din2, Din1});
      end
      if (r.lat < 0) begin
        if (!Load_N) r.load_lows++;
        if (!Clear_N) r.clr_lows++;
        if (P && Clear_N) r.run_cyc++;
        if (T_hi !== (T_lo && q[3:0] == 4'hF)) r.thi_err++;
        if (reset && !(!Clear_N && Load_N && !P && !T_lo && !T_hi)) r.rst_bad++;
      end
      if (done) r.done_cnt++;
      if (cyc >= stop_at) begin
        r.q_end = int'(q); r.busy_end = int'(busy); r.din_end = int'({Din2, Din1});
        break;
      end
      inc_prev  = Clear_N && Load_N && P && T_lo;
      hold_prev = Clear_N && Load_N && !(P && T_lo);
      q_prev    = q;
      @(posedge clk); #1;
    end
    start = 1'b0; pause = 1'b0; abort = 1'b0; reset = 1'b0;
  endtask

  initial begin
    res_t r;
    int   k, last, qbad, zero_seen, ndone;

    // reset values while reset is held
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst.Clear_N", int'(Clear_N), 0);
    check_eq("rst.Load_N", int'(Load_N), 1);
    check_eq("rst.P_T", int'({P, T_lo, T_hi}), 0);
    check_eq("rst.busy_done", int'({busy, done}), 0);
    check_eq("rst.Din", int'({Din2, Din1}), 0);
    check_eq("rst.q", int'(q), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle.Clear_N", int'(Clear_N), 1);
    @(posedge clk); #1;

    expect_normal("f0", 8'hF0, 0);
    run_op(8'hF0, 8'h00, -1, 0, -1, -1, -1, r); score_res(r); do_reset();

    expect_normal("ff", 8'hFF, 0);
    run_op(8'hFF, 8'h00, -1, 0, -1, -1, -1, r); score_res(r); do_reset();

    expect_normal("00", 8'h00, 0);
    run_op(8'h00, 8'h00, -1, 0, -1, -1, -1, r); score_res(r); do_reset();

    expect_res("pause", 11, 8'hFC, 8'hFC, int'(AUTO), 1, 0, 4, 2, 0);
    run_op(8'hFC, 8'h00, 8'hFE, 5, -1, -1, -1, r); score_res(r); do_reset();

    expect_normal("busy_start", 8'hF0, 0);
    run_op(8'hF0, 8'h10, -1, 0, -1, 5, -1, r); score_res(r); do_reset();

    expect_res("abort42", -1, 0, 8'h40, 0, 0, 0, 2, 1, 1);
    run_op(8'h40, 8'h00, -1, 0, 8'h42, -1, -1, r); score_res(r); do_reset();

    expect_res("abort_term", -1, 0, 8'hFE, 0, 0, 0, 1, 1, 1);
    run_op(8'hFE, 8'h00, -1, 0, 8'hFF, -1, -1, r); score_res(r); do_reset();

    expect_res("reset_mid", -1, 0, 0, 0, 0, 0, 8, 1, 1);
    run_op(8'h80, 8'h00, -1, 0, -1, -1, 10, r); score_res(r); do_reset();

`ifdef COUNTER_74163_AUTORELOAD_EN
    // periodic: done every 6 cycles, Q runs FA..FF then FA again
    expect_normal("auto_fa", 8'hFA, 0);
    run_op(8'hFA, 8'h00, -1, 0, -1, -1, -1, r); score_res(r);
    push_exp("auto.int1", 6); push_exp("auto.int2", 6); push_exp("auto.int3", 6);
    push_exp("auto.qbad", 0); push_exp("auto.zero", 0); push_exp("auto.ndone", 3);
    last = 0; qbad = 0; zero_seen = 0; ndone = 0;
    for (int idx = 1; idx < 20; idx++) begin
      if (idx > 1) begin @(posedge clk); #1; @(negedge clk); end
      if (q != 8'hFA + 8'(idx % 6)) qbad++;
      if (q == 8'h00) zero_seen++;
      if (done) begin
        ndone++;
        if (ndone <= 3) pop_check(idx - last);
        last = idx;
      end
    end
    while (ndone < 3) begin pop_check(-1); ndone++; end
    pop_check(qbad); pop_check(zero_seen); pop_check(ndone);
    do_reset();
`else
    // start in the done cycle of a one-shot is accepted
    expect_normal("start_in_done", 8'hF0, 0);
    push_exp("sid.Load_N", 0); push_exp("sid.busy", 1); push_exp("sid.din", 8'hFF);
    push_exp("sid.lat2", 3);   push_exp("sid.q2", 8'hFF);
    run_op(8'hF0, 8'hFF, -1, 0, -1, 18, -1, r); score_res(r);
    pop_check(int'(Load_N)); pop_check(int'(busy)); pop_check(int'({Din2, Din1}));
    k = 1;
    while (!done && k < 20) begin
      @(posedge clk); #1; @(negedge clk);
      k++;
    end
    pop_check(k); pop_check(int'(q));
    do_reset();
`endif

    check_eq("sb_drained", val_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
